// File: rtl/gbe_rx_pkg.sv
// Shared types and constants for the 1G receive port arbiter.
// Error bit positions, FSM states and a mod-to-bytes helper.
package gbe_rx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } arb_state_t;

  localparam int PKT_ERR_CRC      = 0;
  localparam int PKT_ERR_OVERSIZE = 1;
  localparam int PKT_ERR_FRAMING  = 2;

  localparam logic [2:0] MOD_FULL_WORD = 3'd0;

  // Valid bytes carried by an eop word.
  function automatic logic [3:0] mod_bytes(
    input logic [2:0] m
  );
    if (m == MOD_FULL_WORD) begin
      return 4'd8;
    end
    return {1'b0, m};
  endfunction

endpackage

// File: rtl/gbe_rx_port_arb_if.sv
// Packet FIFO side and merged stream side of the arbiter.
// master = arbiter, slave = FIFOs plus downstream sink.
interface gbe_rx_port_arb_if #(
  parameter int PORTS_CNT = 4
);

  logic [PORTS_CNT-1:0]    pkt_avail_i;
  logic [PORTS_CNT*64-1:0] pkt_data_i;
  logic [PORTS_CNT-1:0]    pkt_sop_i;
  logic [PORTS_CNT-1:0]    pkt_eop_i;
  logic [PORTS_CNT*3-1:0]  pkt_mod_i;
  logic [PORTS_CNT-1:0]    frame_crc_err_i;
  logic [PORTS_CNT-1:0]    fifo_rd_req_o;
  logic                    tr_en_fifo_full_i;
  logic [63:0]             pkt_data_o;
  logic                    pkt_sop_o;
  logic                    pkt_eop_o;
  logic [2:0]              pkt_mod_o;
  logic [2:0]              pkt_port_o;
  logic [15:0]             pkt_len_o;
  logic [2:0]              pkt_error_o;
  logic                    pkt_val_o;

  modport master (
    input  pkt_avail_i,
    input  pkt_data_i,
    input  pkt_sop_i,
    input  pkt_eop_i,
    input  pkt_mod_i,
    input  frame_crc_err_i,
    input  tr_en_fifo_full_i,
    output fifo_rd_req_o,
    output pkt_data_o,
    output pkt_sop_o,
    output pkt_eop_o,
    output pkt_mod_o,
    output pkt_port_o,
    output pkt_len_o,
    output pkt_error_o,
    output pkt_val_o
  );

  modport slave (
    output pkt_avail_i,
    output pkt_data_i,
    output pkt_sop_i,
    output pkt_eop_i,
    output pkt_mod_i,
    output frame_crc_err_i,
    output tr_en_fifo_full_i,
    input  fifo_rd_req_o,
    input  pkt_data_o,
    input  pkt_sop_o,
    input  pkt_eop_o,
    input  pkt_mod_o,
    input  pkt_port_o,
    input  pkt_len_o,
    input  pkt_error_o,
    input  pkt_val_o
  );

endinterface

// File: rtl/gbe_rx_port_arb_rr_select.sv
// Rotating priority encoder: first set request at or after ptr.
// Search wraps modulo N; found_o low when no request is set.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Walk N positions from the pointer, keep the first hit.
  always_comb begin
    int p;
    p       = 0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = int'(ptr_i) + i;
      if (p >= N) begin
        p = p - N;
      end
      if (!found_o && req_i[p]) begin
        found_o = 1'b1;
        idx_o   = IW'(p);
      end
    end
  end

endmodule

// File: rtl/gbe_rx_port_arb.sv
// Packet-granular round-robin merge of 1G receive packet FIFOs.
// Forwards whole packets, adds length and error flags on eop.
module gbe_rx_port_arb
  import gbe_rx_pkg::*;
#(
  parameter int PORTS_CNT = 4,
  parameter int MAX_LEN   = 9600
) (
  input logic              clk_sys_i,
  input logic              rst_n_i,
  gbe_rx_port_arb_if.master bus
);

  arb_state_t  state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_q, grant_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        ferr_q, ferr_d;

  logic [63:0] data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [2:0]  mod_q, mod_d;
  logic [2:0]  port_q, port_d;
  logic [15:0] len_q, len_d;
  logic [2:0]  err_q, err_d;
  logic        val_q, val_d;

  logic [2:0]  sel_idx;
  logic        sel_found;

  logic [63:0] h_data;
  logic        h_sop;
  logic        h_eop;
  logic [2:0]  h_mod;
  logic        h_crc;

  logic                 pop;
  logic [PORTS_CNT-1:0] rd_req;
  logic                 first;
  logic                 frame_bad;
  logic                 ferr_next;
  logic [19:0]          len_raw;
  logic [15:0]          len_sat;
  logic                 oversize;
  logic [15:0]          wcnt_inc;
  logic [2:0]           grant_nxt;

  rr_select #(
    .N  (PORTS_CNT),
    .IW (3)
  ) u_rr_select (
    .req_i   (bus.pkt_avail_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  // Head word of the granted port.
  always_comb begin
    h_data = '0;
    h_sop  = 1'b0;
    h_eop  = 1'b0;
    h_mod  = '0;
    h_crc  = 1'b0;
    for (int i = 0; i < PORTS_CNT; i++) begin
      if (grant_q == 3'(i)) begin
        h_data = bus.pkt_data_i[i*64 +: 64];
        h_sop  = bus.pkt_sop_i[i];
        h_eop  = bus.pkt_eop_i[i];
        h_mod  = bus.pkt_mod_i[i*3 +: 3];
        h_crc  = bus.frame_crc_err_i[i];
      end
    end
  end

  assign pop = (state_q == READ) && !bus.tr_en_fifo_full_i;

  // One-hot pop strobe toward the granted FIFO.
  always_comb begin
    rd_req = '0;
    for (int i = 0; i < PORTS_CNT; i++) begin
      rd_req[i] = pop && (grant_q == 3'(i));
    end
  end

  assign bus.fifo_rd_req_o = rd_req;

  // Per-word length, framing and oversize evaluation.
  always_comb begin
    first     = (wcnt_q == 16'd0);
    frame_bad = first ? !h_sop : h_sop;
    ferr_next = ferr_q | frame_bad;
    len_raw   = {1'b0, wcnt_q, 3'b000} + {16'd0, mod_bytes(h_mod)};
    len_sat   = (|len_raw[19:16]) ? 16'hFFFF : len_raw[15:0];
    oversize  = (len_raw > 20'(MAX_LEN));
    wcnt_inc  = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
    grant_nxt = (grant_q == 3'(PORTS_CNT - 1)) ? 3'd0
                                               : grant_q + 3'd1;
  end

  // Arbitration FSM and output word register next state.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wcnt_d   = wcnt_q;
    ferr_d   = ferr_q;
    port_d   = port_q;
    data_d   = '0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    mod_d    = '0;
    len_d    = '0;
    err_d    = '0;
    val_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel_idx;
          port_d  = sel_idx;
          wcnt_d  = '0;
          ferr_d  = 1'b0;
          state_d = READ;
        end
      end
      READ: begin
        if (pop) begin
          val_d  = 1'b1;
          data_d = h_data;
          sop_d  = h_sop & first;
          eop_d  = h_eop;
          mod_d  = h_mod;
          wcnt_d = wcnt_inc;
          ferr_d = ferr_next;
          if (h_eop) begin
            len_d                   = len_sat;
            err_d[PKT_ERR_CRC]      = h_crc;
            err_d[PKT_ERR_OVERSIZE] = oversize;
            err_d[PKT_ERR_FRAMING]  = ferr_next;
            rr_ptr_d                = grant_nxt;
            state_d                 = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered output word.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wcnt_q   <= '0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      mod_q    <= '0;
      port_q   <= '0;
      len_q    <= '0;
      err_q    <= '0;
      val_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wcnt_q   <= wcnt_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      mod_q    <= mod_d;
      port_q   <= port_d;
      len_q    <= len_d;
      err_q    <= err_d;
      val_q    <= val_d;
    end
  end

  assign bus.pkt_data_o  = data_q;
  assign bus.pkt_sop_o   = sop_q;
  assign bus.pkt_eop_o   = eop_q;
  assign bus.pkt_mod_o   = mod_q;
  assign bus.pkt_port_o  = port_q;
  assign bus.pkt_len_o   = len_q;
  assign bus.pkt_error_o = err_q;
  assign bus.pkt_val_o   = val_q;

endmodule

// File: tb/tb_gbe_rx_port_arb.sv
// Bench for gbe_rx_port_arb: FIFO models, packet-level RR model.
// Expected stream is built per packet from port queues.
module tb_gbe_rx_port_arb;

  localparam int P   = 4;
  localparam int MXL = 9600;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        crc;
  } word_t;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic [2:0]  port;
    logic [15:0] len;
    logic [2:0]  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  gbe_rx_port_arb_if #(.PORTS_CNT(P)) bus ();

  gbe_rx_port_arb #(
    .PORTS_CNT (P),
    .MAX_LEN   (MXL)
  ) dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n),
    .bus       (bus.master)
  );

  word_t       fq[P][$];
  word_t       pendw[P][$];
  int          plen[P][$];
  logic [2:0]  perr[P][$];
  exp_t        expq[$];
  bit          fullq[$];

  int checks = 0;
  int failures = 0;
  int rr = 0;
  bit bp_mode = 0;
  int vcount = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int port, input int nbytes,
                         input bit crc, input bit bad_sop,
                         input bit mid_sop);
    int nw;
    int lastb;
    bit ms;
    word_t w;
    nw    = (nbytes + 7) / 8;
    lastb = nbytes - (nw - 1) * 8;
    ms    = mid_sop && (nw > 2);
    for (int i = 0; i < nw; i++) begin
      w.d   = {$urandom, $urandom};
      w.sop = (i == 0) ? !bad_sop : (ms && i == 1);
      w.eop = (i == nw - 1);
      w.mod = w.eop ? ((lastb == 8) ? 3'd0 : 3'(lastb)) : 3'd0;
      w.crc = w.eop ? crc : 1'($urandom_range(0, 1));
      fq[port].push_back(w);
      pendw[port].push_back(w);
    end
    plen[port].push_back((nbytes > 65535) ? 65535 : nbytes);
    perr[port].push_back({bad_sop | ms, nbytes > MXL, crc});
  endtask

  // Round-robin at packet granularity over pending packets.
  task automatic plan();
    bit any;
    int p;
    int ln;
    logic [2:0] er;
    word_t w;
    exp_t e;
    bit first;
    forever begin
      any = 0;
      p = 0;
      for (int i = 0; i < P; i++) begin
        if (!any && plen[(rr + i) % P].size() > 0) begin
          any = 1;
          p = (rr + i) % P;
        end
      end
      if (!any) break;
      ln = plen[p].pop_front();
      er = perr[p].pop_front();
      first = 1;
      do begin
        w = pendw[p].pop_front();
        e.d    = w.d;
        e.sop  = first && w.sop;
        e.eop  = w.eop;
        e.mod  = w.mod;
        e.port = 3'(p);
        e.len  = w.eop ? 16'(ln) : 16'd0;
        e.err  = w.eop ? er : 3'd0;
        expq.push_back(e);
        first = 0;
      end while (!w.eop);
      rr = (p + 1) % P;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      if (fq[p].size() > 0) begin
        bus.pkt_avail_i[p]          = 1'b1;
        bus.pkt_data_i[p*64 +: 64]  = fq[p][0].d;
        bus.pkt_sop_i[p]            = fq[p][0].sop;
        bus.pkt_eop_i[p]            = fq[p][0].eop;
        bus.pkt_mod_i[p*3 +: 3]     = fq[p][0].mod;
        bus.frame_crc_err_i[p]      = fq[p][0].crc;
      end else begin
        bus.pkt_avail_i[p]          = 1'b0;
        bus.pkt_data_i[p*64 +: 64]  = '0;
        bus.pkt_sop_i[p]            = 1'b0;
        bus.pkt_eop_i[p]            = 1'b0;
        bus.pkt_mod_i[p*3 +: 3]     = '0;
        bus.frame_crc_err_i[p]      = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [P-1:0] rq;
    exp_t e;
    @(negedge clk);
    if (fullq.size() > 0) bus.tr_en_fifo_full_i = fullq.pop_front();
    else bus.tr_en_fifo_full_i = bp_mode && ($urandom_range(0, 99) < 30);
    drive();
    #1;
    rq = bus.fifo_rd_req_o;
    if (bus.tr_en_fifo_full_i) chk("no_pop_when_full", 64'(rq), 64'd0);
    chk("rdreq_onehot", 64'($countones(rq) > 1), 64'd0);
    @(posedge clk);
    for (int p = 0; p < P; p++) begin
      if (rq[p] && fq[p].size() > 0) void'(fq[p].pop_front());
    end
    #1;
    chk("val_after_pop", 64'(bus.pkt_val_o), 64'(rq != '0));
    if (bus.pkt_val_o) begin
      vcount++;
      if (expq.size() == 0) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        chk("data", bus.pkt_data_o, e.d);
        chk("sop", 64'(bus.pkt_sop_o), 64'(e.sop));
        chk("eop", 64'(bus.pkt_eop_o), 64'(e.eop));
        chk("port", 64'(bus.pkt_port_o), 64'(e.port));
        chk("len", 64'(bus.pkt_len_o), 64'(e.len));
        chk("err", 64'(bus.pkt_error_o), 64'(e.err));
        if (e.eop) chk("mod", 64'(bus.pkt_mod_o), 64'(e.mod));
      end
    end
  endtask

  function automatic int fifo_words();
    int n = 0;
    for (int p = 0; p < P; p++) n += fq[p].size();
    return n;
  endfunction

  task automatic run(input string tag, input int maxcyc);
    int n = 0;
    while ((expq.size() > 0 || fifo_words() > 0) && n < maxcyc) begin
      tick();
      n++;
    end
    chk({tag, "_stream_done"}, 64'(expq.size()), 64'd0);
    chk({tag, "_fifos_empty"}, 64'(fifo_words()), 64'd0);
    tick();
    tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"}, bus.pkt_data_o, 64'd0);
    chk({tag, "_ctl"},
        64'({bus.pkt_sop_o, bus.pkt_eop_o, bus.pkt_mod_o,
             bus.pkt_port_o, bus.pkt_len_o, bus.pkt_error_o,
             bus.pkt_val_o, bus.fifo_rd_req_o}), 64'd0);
  endtask

  initial begin
    bus.tr_en_fifo_full_i = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 64-byte frame on port 0
    vcount = 0;
    add_pkt(0, 64, 0, 0, 0);
    plan();
    run("p0_64", 200);
    chk("p0_64_words", 64'(vcount), 64'd8);

    // move rr pointer to 2, then ports 1 and 3 together
    add_pkt(1, 16, 0, 0, 0);
    plan();
    run("ptr_to_2", 100);
    add_pkt(1, 40, 0, 0, 0);
    add_pkt(3, 24, 0, 0, 0);
    plan();
    run("p1_p3", 200);
    add_pkt(0, 8, 0, 0, 0);
    add_pkt(2, 8, 0, 0, 0);
    plan();
    run("ptr_is_2", 100);

    // 61-byte frame with CRC error, random backpressure
    bp_mode = 1;
    add_pkt(2, 61, 1, 0, 0);
    plan();
    run("crc61", 300);
    bp_mode = 0;

    // full held 5 cycles, covering the eop pop
    add_pkt(3, 24, 0, 0, 0);
    plan();
    fullq = '{0, 0, 0, 1, 1, 1, 1, 1};
    run("stall_eop", 100);

    // oversize frame, all 1201 words forwarded
    bp_mode = 1;
    vcount = 0;
    add_pkt(1, 9608, 0, 0, 0);
    plan();
    run("oversize", 5000);
    chk("oversize_words", 64'(vcount), 64'd1201);

    // random mix
    for (int k = 0; k < 14; k++) begin
      add_pkt($urandom_range(0, P - 1), $urandom_range(1, 300),
              1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0));
    end
    plan();
    run("random", 6000);
    bp_mode = 0;

    // first word without sop
    add_pkt(0, 32, 0, 1, 0);
    plan();
    run("bad_sop", 100);

    // reset in the middle of a packet
    add_pkt(3, 160, 0, 0, 0);
    plan();
    repeat (6) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    for (int p = 0; p < P; p++) begin
      fq[p].delete();
      pendw[p].delete();
      plen[p].delete();
      perr[p].delete();
    end
    expq.delete();
    rr = 0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    add_pkt(2, 16, 0, 0, 0);
    add_pkt(0, 16, 0, 0, 0);
    plan();
    run("after_reset", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
